// File: rtl/i2s_record_receiver.sv
// rtl/i2s_record_receiver.sv - I2S record-stream deserializer producing {left, right} stereo words
// Optional feature macro: I2S_RX_TEST_PATTERN_EN (test_mode selects a frame-count pattern word)
module i2s_record_receiver #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      ac_bclk,
   input  logic                      ac_reclrc,
   input  logic                      ac_recdat,
   input  logic                      test_mode,
   output logic [2*SAMPLE_WIDTH-1:0] sample_data,
   output logic                      sample_valid,
   input  logic                      sample_ready,
   output logic                      overflow,
   output logic                      short_word_err,
   input  logic                      clear_status,
   output logic [31:0]               frame_count
);

   localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);

   typedef enum logic [2:0] {
      SEEK      = 3'd0,
      L_SHIFT   = 3'd1,
      L_WAIT    = 3'd2,
      R_SHIFT   = 3'd3,
      PAIR_DONE = 3'd4,
      R_WAIT    = 3'd5
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0]    bclk_sync_q, bclk_sync_d;
   logic [SYNC_STAGES-1:0]    lrc_sync_q,  lrc_sync_d;
   logic [SYNC_STAGES-1:0]    dat_sync_q,  dat_sync_d;
   logic                      bclk_prev_q, bclk_prev_d;
   logic                      lrc_prev_q,  lrc_prev_d;
   logic [CNT_W-1:0]          cnt_q,       cnt_d;
   logic [SAMPLE_WIDTH-2:0]   shift_q,     shift_d;
   logic [SAMPLE_WIDTH-1:0]   left_hold_q, left_hold_d;
   logic [2*SAMPLE_WIDTH-1:0] data_q,      data_d;
   logic                      valid_q,     valid_d;
   logic                      ovf_q,       ovf_d;
   logic                      short_q,     short_d;
   logic [31:0]               fc_q,        fc_d;

   logic                      bclk_s, lrc_s, dat_s;
   logic                      bclk_rise, lrc_chg, word_done;
   logic [SAMPLE_WIDTH-1:0]   word;
   logic                      short_evt, pair_evt;
   logic [2*SAMPLE_WIDTH-1:0] new_word;

   assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
   assign lrc_s     = lrc_sync_q[SYNC_STAGES-1];
   assign dat_s     = dat_sync_q[SYNC_STAGES-1];
   assign bclk_rise = bclk_s & ~bclk_prev_q;
   assign lrc_chg   = bclk_rise & (lrc_s != lrc_prev_q);
   // The bit completing the word is used directly from the synchronizer, so the
   // shift register only needs to hold the first SAMPLE_WIDTH-1 bits.
   assign word      = {shift_q, dat_s};
   assign word_done = bclk_rise & ~lrc_chg & (cnt_q == CNT_W'(SAMPLE_WIDTH - 1));
   assign short_evt = lrc_chg & ((state_q == L_SHIFT) | (state_q == R_SHIFT));
   // Pair completion is acted on in the same cycle the FSM moves into PAIR_DONE,
   // so sample_valid rises one clock after the right-channel LSB is sampled.
   assign pair_evt  = (state_q == R_SHIFT) & word_done;

   assign sample_data    = data_q;
   assign sample_valid   = valid_q;
   assign overflow       = ovf_q;
   assign short_word_err = short_q;
   assign frame_count    = fc_q;

`ifdef I2S_RX_TEST_PATTERN_EN
   // Test pattern uses the count value before this pair increments it.
   always_comb begin
      new_word = {left_hold_q, word};
      if (test_mode) begin
         new_word = {fc_q[SAMPLE_WIDTH-1:0], ~fc_q[SAMPLE_WIDTH-1:0]};
      end
   end
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
   // Captured data only; the pattern generator is not built.
   always_comb begin
      new_word = {left_hold_q, word};
   end
`endif

   // Input synchronizers, bclk edge detect, slot bit counter and shift register.
   always_comb begin
      bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], ac_bclk};
      lrc_sync_d  = {lrc_sync_q[SYNC_STAGES-2:0],  ac_reclrc};
      dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0],  ac_recdat};
      bclk_prev_d = bclk_s;
      lrc_prev_d  = lrc_prev_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      if (bclk_rise) begin
         lrc_prev_d = lrc_s;
         if (lrc_chg) begin
            // Delay bit of the new slot: not captured.
            cnt_d = '0;
         end else if (cnt_q < CNT_W'(SAMPLE_WIDTH)) begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = {shift_q[SAMPLE_WIDTH-3:0], dat_s};
         end
      end
   end

   // Next-state logic for slot framing.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SEEK: begin
            if (lrc_chg && !lrc_s) state_d = L_SHIFT;
         end
         L_SHIFT: begin
            if (lrc_chg)        state_d = lrc_s ? SEEK : L_SHIFT;
            else if (word_done) state_d = L_WAIT;
         end
         L_WAIT: begin
            if (lrc_chg) state_d = lrc_s ? R_SHIFT : L_SHIFT;
         end
         R_SHIFT: begin
            if (lrc_chg)        state_d = lrc_s ? SEEK : L_SHIFT;
            else if (word_done) state_d = PAIR_DONE;
         end
         PAIR_DONE: begin
            state_d = R_WAIT;
         end
         R_WAIT: begin
            if (lrc_chg && !lrc_s) state_d = L_SHIFT;
         end
         default: state_d = SEEK;
      endcase
   end

   // Output datapath: left latch, stereo word load, handshake, sticky flags, counter.
   always_comb begin
      left_hold_d = left_hold_q;
      data_d      = data_q;
      valid_d     = valid_q;
      ovf_d       = ovf_q;
      short_d     = short_q;
      fc_d        = fc_q;

      if (clear_status) begin
         ovf_d   = 1'b0;
         short_d = 1'b0;
      end

      if ((state_q == L_SHIFT) && word_done) begin
         left_hold_d = word;
      end

      if (short_evt) begin
         short_d     = 1'b1;
         left_hold_d = '0;
      end

      if (valid_q && sample_ready) begin
         valid_d = 1'b0;
      end

      if (pair_evt) begin
         fc_d = fc_q + 32'd1;
         if (!valid_q || sample_ready) begin
            data_d  = new_word;
            valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= SEEK;
         bclk_sync_q <= '0;
         lrc_sync_q  <= '0;
         dat_sync_q  <= '0;
         bclk_prev_q <= 1'b0;
         lrc_prev_q  <= 1'b0;
         cnt_q       <= '0;
         shift_q     <= '0;
         left_hold_q <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         ovf_q       <= 1'b0;
         short_q     <= 1'b0;
         fc_q        <= '0;
      end else begin
         state_q     <= state_d;
         bclk_sync_q <= bclk_sync_d;
         lrc_sync_q  <= lrc_sync_d;
         dat_sync_q  <= dat_sync_d;
         bclk_prev_q <= bclk_prev_d;
         lrc_prev_q  <= lrc_prev_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         left_hold_q <= left_hold_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         ovf_q       <= ovf_d;
         short_q     <= short_d;
         fc_q        <= fc_d;
      end
   end

endmodule
